// File: rtl/stream_out_ctrl.sv
// Output-side stream controller for the accelerator result path.
// Waits for a (optionally delayed) core-finish pulse qualified by the final-round
// flag, then reads burst_len+1 words from a 1-cycle-latency result buffer and
// presents them as an AXI-stream-style master. dst_ready low stalls everything.
module stream_out_ctrl #(
    parameter int AW           = 8,
    parameter int LASTW        = 16,
    parameter int FIN_DELAY    = 0,
    parameter int STREAM_EVERY = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             get_fin,
    input  logic             get_v,
    input  logic [LASTW-1:0] last,
    input  logic [AW-1:0]    burst_len,
    input  logic             dst_ready,
    output logic             dst_valid,
    output logic             dst_last,
    output logic             stream_v,
    output logic [AW-1:0]    stream_a,
    output logic             busy,
    output logic [15:0]      frame_cnt
);

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t         state_reg;
    state_t         state_next;
    logic           fin_d;
    logic           last_q1_reg;
    logic           last_q_reg;
    logic           fin_pend_reg;
    logic           last_pend_reg;
    logic           qual;
    logic           trigger;
    logic           burst_done;
    logic [AW-1:0]  cnt_reg;
    logic [AW-1:0]  len_q_reg;
    logic [15:0]    frame_cnt_reg;
    logic           dst_valid_reg;
    logic           dst_last_reg;

    // Align the finish pulse with the core's count; zero stages is a wire.
    generate
        if (FIN_DELAY == 0) begin : g_fin_comb
            assign fin_d = get_fin;
        end else begin : g_fin_pipe
            logic [FIN_DELAY-1:0] fin_sr_reg;

            // Shift the finish pulse through FIN_DELAY flops.
            always_ff @(posedge clk) begin
                if (rst) begin
                    fin_sr_reg <= '0;
                end else begin
                    for (int i = FIN_DELAY - 1; i > 0; i--) begin
                        fin_sr_reg[i] <= fin_sr_reg[i-1];
                    end
                    fin_sr_reg[0] <= get_fin;
                end
            end

            assign fin_d = fin_sr_reg[FIN_DELAY-1];
        end
    endgenerate

    // Final-round flag, delayed two cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q1_reg <= 1'b0;
            last_q_reg  <= 1'b0;
        end else begin
            last_q1_reg <= (last != '0);
            last_q_reg  <= last_q1_reg;
        end
    end

    // Hold fin/last events that arrive while busy or before qualification.
    // A new round (get_v) discards a stale fin, even one arriving that cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            fin_pend_reg  <= 1'b0;
            last_pend_reg <= 1'b0;
        end else begin
            if (trigger || get_v) begin
                fin_pend_reg <= 1'b0;
            end else if (fin_d) begin
                fin_pend_reg <= 1'b1;
            end
            if (trigger) begin
                last_pend_reg <= 1'b0;
            end else if (last_q_reg) begin
                last_pend_reg <= 1'b1;
            end
        end
    end

    assign qual       = (STREAM_EVERY != 0) ? 1'b1 : (last_q_reg | last_pend_reg);
    assign trigger    = (state_reg == IDLE) & (fin_d | fin_pend_reg) & qual & dst_ready;
    assign burst_done = (state_reg == STREAM) & dst_ready & (cnt_reg == len_q_reg);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (trigger)    state_next = STREAM;
            STREAM:  if (burst_done) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Beat counter, captured length and completed-frame counter.
    // The counter returns to 0 on the final beat so it never exceeds len_q and
    // the read address rests at 0 while idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg       <= '0;
            len_q_reg     <= '0;
            frame_cnt_reg <= '0;
        end else if (trigger) begin
            cnt_reg   <= '0;
            len_q_reg <= burst_len;
        end else if ((state_reg == STREAM) && dst_ready) begin
            if (cnt_reg == len_q_reg) begin
                cnt_reg       <= '0;
                frame_cnt_reg <= frame_cnt_reg + 16'd1;
            end else begin
                cnt_reg <= cnt_reg + AW'(1);
            end
        end
    end

    // Output beat flags follow the buffer read by one cycle; frozen on stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            dst_valid_reg <= 1'b0;
            dst_last_reg  <= 1'b0;
        end else if (dst_ready) begin
            dst_valid_reg <= (state_reg == STREAM);
            dst_last_reg  <= (state_reg == STREAM) && (cnt_reg == len_q_reg);
        end
    end

    assign stream_v  = (state_reg == STREAM) & dst_ready;
    assign stream_a  = cnt_reg;
    assign busy      = (state_reg == STREAM);
    assign dst_valid = dst_valid_reg;
    assign dst_last  = dst_last_reg;
    assign frame_cnt = frame_cnt_reg;

endmodule

// File: tb/tb_stream_out_ctrl.sv
// Bench for stream_out_ctrl: table of single-burst vectors plus hand-written
// sequences for qualification, new-round discard, reset abort and fin delay.
module tb_stream_out_ctrl;

    localparam int AW    = 8;
    localparam int LASTW = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             get_fin;
    logic             get_v;
    logic [LASTW-1:0] last;
    logic [AW-1:0]    burst_len;
    logic             dst_ready;

    logic             dst_valid0, dst_last0, stream_v0, busy0;
    logic [AW-1:0]    stream_a0;
    logic [15:0]      frame_cnt0;
    logic             dst_valid1, dst_last1, stream_v1, busy1;
    logic [AW-1:0]    stream_a1;
    logic [15:0]      frame_cnt1;

    stream_out_ctrl #(.AW(AW), .LASTW(LASTW), .FIN_DELAY(0), .STREAM_EVERY(0)) dut0 (
        .clk(clk), .rst(rst), .get_fin(get_fin), .get_v(get_v), .last(last),
        .burst_len(burst_len), .dst_ready(dst_ready), .dst_valid(dst_valid0),
        .dst_last(dst_last0), .stream_v(stream_v0), .stream_a(stream_a0),
        .busy(busy0), .frame_cnt(frame_cnt0)
    );

    stream_out_ctrl #(.AW(AW), .LASTW(LASTW), .FIN_DELAY(2), .STREAM_EVERY(1)) dut1 (
        .clk(clk), .rst(rst), .get_fin(get_fin), .get_v(get_v), .last(last),
        .burst_len(burst_len), .dst_ready(dst_ready), .dst_valid(dst_valid1),
        .dst_last(dst_last1), .stream_v(stream_v1), .stream_a(stream_a1),
        .busy(busy1), .frame_cnt(frame_cnt1)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard: expected read addresses and expected dst_last per beat.
    int addr_q[$];
    int lastf_q[$];
    int beat_cnt  = 0;
    int last_seen = -1;
    bit mon_en    = 1'b0;

    task automatic push_burst(input int len);
        for (int i = 0; i <= len; i++) begin
            addr_q.push_back(i);
            lastf_q.push_back(i == len ? 1 : 0);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (stream_v0) begin
                if (addr_q.size() == 0) chk("stray_read", 1, 0);
                else chk("read_addr", int'(stream_a0), addr_q.pop_front());
            end
            if (dst_valid0 && dst_ready) begin
                beat_cnt++;
                if (dst_last0) last_seen = cyc;
                if (lastf_q.size() == 0) chk("stray_beat", 1, 0);
                else chk("beat_last", int'(dst_last0), lastf_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        get_fin   = 1'b0;
        get_v     = 1'b0;
        dst_ready = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    typedef struct {
        int len;
        int stall_at;
        int stall_len;
        int beats;
        int off;
    } vec_t;

    vec_t vecs[5];
    int   t0;

    initial begin
        vecs[0] = '{len: 3,   stall_at: 0, stall_len: 0, beats: 4,   off: 5};
        vecs[1] = '{len: 3,   stall_at: 2, stall_len: 2, beats: 4,   off: 7};
        vecs[2] = '{len: 0,   stall_at: 0, stall_len: 0, beats: 1,   off: 2};
        vecs[3] = '{len: 255, stall_at: 0, stall_len: 0, beats: 256, off: 257};
        vecs[4] = '{len: 1,   stall_at: 0, stall_len: 1, beats: 2,   off: 4};

        rst = 1'b1; get_fin = 1'b0; get_v = 1'b0; last = '0;
        burst_len = '0; dst_ready = 1'b1;
        tick();
        do_reset();

        chk("rst_dst_valid", int'(dst_valid0), 0);
        chk("rst_dst_last",  int'(dst_last0),  0);
        chk("rst_stream_v",  int'(stream_v0),  0);
        chk("rst_stream_a",  int'(stream_a0),  0);
        chk("rst_busy",      int'(busy0),      0);
        chk("rst_frame_cnt", int'(frame_cnt0), 0);
        chk("rst_dut1_valid", int'(dst_valid1), 0);
        mon_en = 1'b1;

        // Table-driven single bursts, final flag held high.
        foreach (vecs[e]) begin
            do_reset();
            last      = 16'd1;
            burst_len = AW'(vecs[e].len);
            tick(); tick(); tick();
            beat_cnt  = 0;
            last_seen = -1;
            push_burst(vecs[e].len);
            t0 = cyc;
            for (int k = 0; k < vecs[e].off + 4; k++) begin
                get_fin   = (k == 0);
                dst_ready = !(vecs[e].stall_len > 0 && k >= vecs[e].stall_at &&
                              k < vecs[e].stall_at + vecs[e].stall_len);
                tick();
            end
            get_fin = 1'b0; dst_ready = 1'b1;
            chk("vec_last_cycle", last_seen - t0, vecs[e].off);
            chk("vec_beats",      beat_cnt,      vecs[e].beats);
            chk("vec_frame_cnt",  int'(frame_cnt0), 1);
            chk("vec_busy",       int'(busy0),   0);
            chk("vec_sb_empty",   addr_q.size() + lastf_q.size(), 0);
        end

        // Fin arrives before the final flag; burst waits for last_q, runs once.
        do_reset();
        last = '0; burst_len = AW'(2);
        tick(); tick();
        beat_cnt = 0; last_seen = -1;
        push_burst(2);
        t0 = cyc;
        for (int k = 0; k < 30; k++) begin
            get_fin = (k == 0);
            if (k == 6) last = 16'd5;
            tick();
        end
        get_fin = 1'b0;
        chk("late_last_cycle", last_seen - t0, 12);
        chk("late_last_beats", beat_cnt, 3);
        chk("late_last_frames", int'(frame_cnt0), 1);
        chk("late_last_sb_empty", addr_q.size() + lastf_q.size(), 0);

        // New round discards the pending fin; no burst afterwards.
        do_reset();
        last = '0; burst_len = AW'(3);
        tick(); tick();
        beat_cnt = 0;
        for (int k = 0; k < 20; k++) begin
            get_fin = (k == 0);
            get_v   = (k == 2);
            if (k == 4) last = 16'd1;
            tick();
        end
        get_fin = 1'b0; get_v = 1'b0;
        chk("discard_beats",  beat_cnt, 0);
        chk("discard_frames", int'(frame_cnt0), 0);
        chk("discard_busy",   int'(busy0), 0);

        // Reset during a 4-beat burst aborts it; the next fin runs in full.
        do_reset();
        last = 16'd1; burst_len = AW'(3);
        tick(); tick(); tick();
        beat_cnt = 0; last_seen = -1;
        addr_q.push_back(0); addr_q.push_back(1); addr_q.push_back(2);
        lastf_q.push_back(0); lastf_q.push_back(0);
        for (int k = 0; k < 3; k++) begin
            get_fin = (k == 0);
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_dst_valid", int'(dst_valid0), 0);
        chk("abort_dst_last",  int'(dst_last0),  0);
        chk("abort_stream_v",  int'(stream_v0),  0);
        chk("abort_stream_a",  int'(stream_a0),  0);
        chk("abort_busy",      int'(busy0),      0);
        chk("abort_frame_cnt", int'(frame_cnt0), 0);
        chk("abort_no_last",   last_seen, -1);
        chk("abort_sb_empty",  addr_q.size() + lastf_q.size(), 0);
        tick(); tick();
        beat_cnt = 0; last_seen = -1;
        push_burst(3);
        t0 = cyc;
        for (int k = 0; k < 10; k++) begin
            get_fin = (k == 0);
            tick();
        end
        get_fin = 1'b0;
        chk("rerun_last_cycle", last_seen - t0, 5);
        chk("rerun_beats",      beat_cnt, 4);
        chk("rerun_frame_cnt",  int'(frame_cnt0), 1);

        // Every-round mode with a 2-stage fin delay, single-beat bursts.
        mon_en = 1'b0;
        do_reset();
        last = '0; burst_len = '0;
        tick(); tick();
        for (int k = 0; k < 11; k++) begin
            get_fin = (k == 0 || k == 2);
            chk("every_dst_valid", int'(dst_valid1), (k == 4 || k == 6) ? 1 : 0);
            chk("every_dst_last",  int'(dst_last1),  (k == 4 || k == 6) ? 1 : 0);
            tick();
        end
        get_fin = 1'b0;
        chk("every_frame_cnt", int'(frame_cnt1), 2);
        chk("every_busy",      int'(busy1), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/stream_out_ctrl.md
Name: stream_out_ctrl

Overview:
- Output-side stream controller for the accelerator result path.
- Waits for core completion (`get_fin`) and, depending on mode, a final-round qualifier (`last`). It then reads a result buffer of 1-cycle read latency and drives an AXI-stream-style master.
- Generalised successor of the fixed single-beat controller:
  - runtime burst length;
  - parametrised fin alignment delay;
  - per-round or final-only streaming mode;
  - completed-frame counter.

Parameters:
- AW, 8, width of buffer read address, burst length and beat counter.
- LASTW, 16, width of `last` input.
- FIN_DELAY, 0, pipeline stages applied to `get_fin` (0..3) to align with the core count.
- STREAM_EVERY, 0, 1 = stream after every completed round; 0 = stream only for rounds qualified by `last`.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- get_fin  in  1  one-cycle pulse: core round finished.
- get_v  in  1  one-cycle pulse: new round started; discards a pending fin.
- last  in  LASTW  nonzero = current round is final.
- burst_len  in  AW  beats minus 1, sampled at trigger.
- dst_ready  in  1  downstream ready; stalls the whole output pipe when low.
- dst_valid  out  1  output beat valid.
- dst_last  out  1  final beat of burst.
- stream_v  out  1  result-buffer read enable.
- stream_a  out  AW  result-buffer read address.
- busy  out  1  state != IDLE.
- frame_cnt  out  16  completed bursts, wraps at 2^16.

Behaviour:
Reset:
- Synchronous, active-high. On the next edge all of the following go to 0: `dst_valid`, `dst_last`, `stream_v`, `stream_a`, `busy`, `frame_cnt`, fin shift register, `last_q` pipe, `fin_pend`, `last_pend`, `cnt`, `len_q`.
- State goes to IDLE.
- Reset mid-burst aborts the burst. `dst_last` is not emitted and `frame_cnt` is not incremented.

Qualifier signals:
- `fin_d` = `get_fin` delayed FIN_DELAY cycles. FIN_DELAY = 0 means combinational pass-through.
- `last_q` = (`last` != 0) registered twice (2-cycle delay).
- `fin_pend`:
  - clear if `trigger` or `get_v`;
  - else set if `fin_d`;
  - clear has priority, so a `fin_d` coincident with `get_v` is dropped.
- `last_pend`: clear on `trigger`; else set on `last_q`.

Trigger:
- `qual` = 1 if STREAM_EVERY = 1; otherwise `qual` = (`last_q` | `last_pend`).
- `trigger` = (state == IDLE) & (`fin_d` | `fin_pend`) & `qual` & `dst_ready`.
- While busy, fin and last events are held pending and re-evaluated on return to IDLE. Multiple fins collapse into one.

FSM, states IDLE and STREAM:
- IDLE to STREAM on `trigger`; at the same time `cnt` <= 0 and `len_q` <= `burst_len`.
- In STREAM:
  - `stream_v` = `dst_ready` (combinational).
  - `stream_a` = `cnt`.
  - When `dst_ready`: `cnt` increments. If `cnt` == `len_q`, return to IDLE and increment `frame_cnt`.
  - `dst_ready` low freezes `cnt` and state.

Output registers (update only when `dst_ready` = 1, otherwise hold):
- `dst_valid` <= (state == STREAM).
- `dst_last` <= (state == STREAM) & (`cnt` == `len_q`).

Latency and beat count:
- Trigger at cycle T gives `stream_v` at T+1 with `stream_a` = 0, and `dst_valid` for beat 0 at T+2.
- A burst is `len_q` + 1 beats. `burst_len` = 0 gives a single beat with `dst_last` set.
- Back-to-back bursts: earliest re-trigger is the cycle after return to IDLE, giving one idle cycle between bursts.
- `cnt` never exceeds `len_q`, so there is no wrap within a burst. `burst_len` = 2^AW−1 gives 2^AW beats.

Test Plan:
- STREAM_EVERY=0, `burst_len`=3, `last`=1 held, `get_fin` pulse at cycle 10, `dst_ready`=1 → `stream_a` 0,1,2,3 on cycles 11–14; `dst_valid` 12–15; `dst_last` only at 15; `frame_cnt`=1.
- Same setup with `dst_ready` low on cycles 12–13 → `stream_a`/`dst_valid`/`dst_last` frozen; 4 beats total; `dst_last` at cycle 17.
- STREAM_EVERY=0, `get_fin` with `last`=0, then `last`=5 raised 6 cycles later → no burst until `last_q` rises; then one burst; `fin_pend` cleared.
- `get_fin` followed by `get_v` before qualification, then `last`=1 → no burst; `frame_cnt` stays 0.
- STREAM_EVERY=1, FIN_DELAY=2, `burst_len`=0, `get_fin` pulses at 10 and 12 → first trigger at 12, single beat with `dst_valid` & `dst_last` at 14; second fin held pending, second beat 2 cycles later; `frame_cnt`=2.
- `rst` asserted during beat 2 of a 4-beat burst → all outputs 0 next cycle; `busy`=0; `frame_cnt` unchanged; a new fin then produces a full burst from address 0.
